shift_seq: RTL and testbench

//  Multi-pass sequencer upstream of the 4-bit-amount barrel shifter in the CPU execute stage.

---
 rtl/shift_seq_if.sv | 23 ++
 rtl/shift_seq.sv | 152 +++++++++++++++
 tb/tb_shift_seq.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/shift_seq_if.sv
// Request/result handshake bundle between the execute-stage issuer, the
// shift sequencer and writeback. The master side issues shift ops and
// consumes results; the slave side is the sequencer.
interface shift_seq_if;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [31:0] req_data;
    logic [4:0]  req_amt;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_data;

    modport master (
        output req_valid, req_op, req_data, req_amt, res_ready,
        input  req_ready, res_valid, res_data
    );

    modport slave (
        input  req_valid, req_op, req_data, req_amt, res_ready,
        output req_ready, res_valid, res_data
    );
endinterface

// File: rtl/shift_seq.sv
// Multi-pass shift sequencer in front of a 4-bit-amount barrel shifter.
// Every shift is turned into a left rotate/shift of L = n (left ops) or
// (32-n) mod 32 (right ops), split into passes of at most MAX_STEP bits.
// Right shifts are finished by masking the wrapped-in upper n bits.
// Build option: define SHIFT_SEQ_SRA_EN to make op 100 an arithmetic right
// shift; without it op 100 is a logical right shift and no sign logic exists.
module shift_seq #(
    parameter int DATA_W   = 32,
    parameter int MAX_STEP = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    shift_seq_if.slave        bus,
    output logic              busy,
    output logic [DATA_W-1:0] sh_sr1,
    output logic [3:0]        sh_shift,
    input  logic [DATA_W-1:0] sh_rot,
    input  logic [DATA_W-1:0] sh_log
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    typedef enum logic [2:0] {OP_SLL, OP_SRL, OP_ROL, OP_ROR, OP_SRA} op_t;

    localparam logic [4:0]        STEP_MAX = 5'(MAX_STEP);
    localparam logic [DATA_W-1:0] ONES     = '1;

    state_t            state;
    op_t               op_q;
    logic [4:0]        amt_q;
    logic [4:0]        rem;
    logic [DATA_W-1:0] acc;
    logic [DATA_W-1:0] sr1_last;
    logic              res_valid_q;
    logic [DATA_W-1:0] res_data_q;
`ifdef SHIFT_SEQ_SRA_EN
    logic              sign_q;
`endif

    op_t               req_kind;
    logic [4:0]        req_left;
    logic [3:0]        step;
    logic [DATA_W-1:0] acc_next;
    logic [DATA_W-1:0] final_val;

    // Decode the request opcode; unused encodings fall back to SLL.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        req_kind = OP_SLL;
        case (bus.req_op)
            3'b001:  req_kind = OP_SRL;
            3'b010:  req_kind = OP_ROL;
            3'b011:  req_kind = OP_ROR;
`ifdef SHIFT_SEQ_SRA_EN
            3'b100:  req_kind = OP_SRA;
`else
            3'b100:  req_kind = OP_SRL;
`endif
            default: req_kind = OP_SLL;
        endcase
    end

    // Left-equivalent amount: right ops become a left rotate by (32-n) mod 32.
    always_comb begin
        req_left = bus.req_amt;
        if (req_kind != OP_SLL && req_kind != OP_ROL) begin
            req_left = 5'd0 - bus.req_amt;
        end
    end

    // Per-pass step, next accumulator and the masked final value of the last pass.
    always_comb begin
        step      = (rem > STEP_MAX) ? STEP_MAX[3:0] : rem[3:0];
        acc_next  = (op_q == OP_SLL) ? sh_log : sh_rot;
        final_val = acc_next;
        case (op_q)
            OP_SRL:  final_val = acc_next & (ONES >> amt_q);
`ifdef SHIFT_SEQ_SRA_EN
            OP_SRA:  final_val = sign_q ? (acc_next | ~(ONES >> amt_q))
                                        : (acc_next & (ONES >> amt_q));
`endif
            default: final_val = acc_next;
        endcase
    end

    // Shifter drive is live during RUN; outside RUN the operand holds and the amount is zero.
    always_comb begin
        sh_sr1   = (state == RUN) ? acc  : sr1_last;
        sh_shift = (state == RUN) ? step : 4'd0;
    end

    assign bus.req_ready = (state == IDLE) & rst_n;
    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_data_q;
    assign busy          = (state != IDLE);

    // Sequencer FSM: accept, run the passes, present the result until taken.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: state uses non-blocking assignment so every register samples pre-edge values.
            state       <= IDLE;
            op_q        <= OP_SLL;
            amt_q       <= '0;
            rem         <= '0;
            acc         <= '0;
            sr1_last    <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
`ifdef SHIFT_SEQ_SRA_EN
            sign_q      <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        op_q  <= req_kind;
                        amt_q <= bus.req_amt;
                        acc   <= bus.req_data;
                        rem   <= req_left;
`ifdef SHIFT_SEQ_SRA_EN
                        sign_q <= bus.req_data[DATA_W-1];
`endif
                        if (req_left == 5'd0) begin
                            res_data_q  <= bus.req_data;
                            res_valid_q <= 1'b1;
                            state       <= DONE;
                        end else begin
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    acc      <= acc_next;
                    rem      <= rem - {1'b0, step};
                    sr1_last <= acc;
                    if (rem == {1'b0, step}) begin
                        res_data_q  <= final_val;
                        res_valid_q <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    if (bus.res_ready) begin
                        res_valid_q <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_shift_seq.sv
// Self-checking bench for shift_seq: behavioural barrel-shifter model on the
// sh_* side, scoreboard of expected results/latencies pushed at accept and
// popped when the result appears. Honours SHIFT_SEQ_SRA_EN for op 100.
module tb_shift_seq;

    logic        clk;
    logic        rst_n;
    logic        busy;
    logic [31:0] sh_sr1;
    logic [3:0]  sh_shift;
    logic [31:0] sh_rot;
    logic [31:0] sh_log;
    logic [63:0] rot_dbl;

    shift_seq_if bus ();

    shift_seq dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .busy     (busy),
        .sh_sr1   (sh_sr1),
        .sh_shift (sh_shift),
        .sh_rot   (sh_rot),
        .sh_log   (sh_log)
    );

    // External barrel shifter: rotate-left and logical-left by sh_shift.
    assign rot_dbl = {sh_sr1, sh_sr1} << sh_shift;
    assign sh_rot  = rot_dbl[63:32];
    assign sh_log  = sh_sr1 << sh_shift;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference shift straight from the op definition.
    function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] d, input logic [4:0] n);
        logic [63:0] dd;
        dd = {d, d};
        case (op)
            3'b001: return d >> n;
            3'b010: begin dd = dd << n; return dd[63:32]; end
            3'b011: begin dd = dd >> n; return dd[31:0]; end
`ifdef SHIFT_SEQ_SRA_EN
            3'b100: return $signed(d) >>> n;
`else
            3'b100: return d >> n;
`endif
            default: return d << n;
        endcase
    endfunction

    task automatic do_op(input string name, input logic [2:0] op, input logic [31:0] d,
                         input logic [4:0] n, input int hold);
        logic [4:0] l;
        int         rem;
        int         stp;
        int         steps[$];
        int         got_steps[$];
        int         lat;
        int         guard;
        exp_t       e;

        l = (op == 3'b001 || op == 3'b011 || op == 3'b100) ? 5'd0 - n : n;
        rem = int'(l);
        while (rem > 0) begin
            stp = (rem > 15) ? 15 : rem;
            steps.push_back(stp);
            rem -= stp;
        end

        bus.req_op    = op;
        bus.req_data  = d;
        bus.req_amt   = n;
        bus.req_valid = 1'b1;
        bus.res_ready = 1'b1;   // asserted early on purpose: must be ignored until res_valid
        guard = 0;
        while (!bus.req_ready && guard < 20) begin
            @(posedge clk); @(negedge clk);
            guard++;
        end
        check({name, "/req_ready"}, 32'(bus.req_ready), 32'd1);
        e.data = model(op, d, n);
        e.lat  = steps.size() + 1;
        sb.push_back(e);
        @(posedge clk); @(negedge clk);
        bus.req_valid = 1'b0;

        lat = 1;
        while (!bus.res_valid && lat < 8) begin
            got_steps.push_back(int'(sh_shift));
            @(posedge clk); @(negedge clk);
            lat++;
        end

        e = sb.pop_front();
        check({name, "/res_valid"}, 32'(bus.res_valid), 32'd1);
        check({name, "/latency"}, 32'(lat), 32'(e.lat));
        check({name, "/data"}, bus.res_data, e.data);
        check({name, "/passes"}, 32'(got_steps.size()), 32'(steps.size()));
        for (int i = 0; i < steps.size() && i < got_steps.size(); i++) begin
            check({name, "/step"}, 32'(got_steps[i]), 32'(steps[i]));
        end
        check({name, "/done_shift0"}, 32'(sh_shift), 32'd0);
        check({name, "/done_req_ready"}, 32'(bus.req_ready), 32'd0);

        if (hold > 0) begin
            bus.res_ready = 1'b0;
            for (int i = 0; i < hold; i++) begin
                @(posedge clk); @(negedge clk);
                check({name, "/hold_valid"}, 32'(bus.res_valid), 32'd1);
                check({name, "/hold_data"}, bus.res_data, e.data);
                check({name, "/hold_req_ready"}, 32'(bus.req_ready), 32'd0);
            end
        end

        // Handshake with a request pending: it must not be taken in DONE.
        bus.res_ready = 1'b1;
        bus.req_valid = 1'b1;
        @(posedge clk); @(negedge clk);
        bus.req_valid = 1'b0;
        bus.res_ready = 1'b0;
        check({name, "/after_valid"}, 32'(bus.res_valid), 32'd0);
        check({name, "/after_busy"}, 32'(busy), 32'd0);
        check({name, "/after_req_ready"}, 32'(bus.req_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n         = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_op    = 3'b000;
        bus.req_data  = 32'h0;
        bus.req_amt   = 5'd0;
        bus.res_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst/res_valid", 32'(bus.res_valid), 32'd0);
        check("rst/res_data", bus.res_data, 32'h0);
        check("rst/sh_sr1", sh_sr1, 32'h0);
        check("rst/sh_shift", 32'(sh_shift), 32'd0);
        check("rst/busy", 32'(busy), 32'd0);
        check("rst/req_ready", 32'(bus.req_ready), 32'd0);
        rst_n = 1'b1;
        #1;
        check("rst/req_ready_rel", 32'(bus.req_ready), 32'd1);
        @(negedge clk);

        do_op("sll20", 3'b000, 32'h0000_0001, 5'd20, 0);
        do_op("ror1", 3'b011, 32'h8000_0001, 5'd1, 0);
        do_op("srl4", 3'b001, 32'h8000_0000, 5'd4, 0);
        do_op("sra4", 3'b100, 32'h8000_0000, 5'd4, 0);
        do_op("sra4pos", 3'b100, 32'h4000_0000, 5'd4, 0);
        for (int i = 0; i < 5; i++) begin
            do_op("n0", 3'(i), 32'hDEAD_BEEF, 5'd0, 0);
        end
        do_op("hold5", 3'b010, 32'h1234_5678, 5'd9, 5);
        do_op("rol31", 3'b010, 32'h8000_0001, 5'd31, 0);
        do_op("srl31", 3'b001, 32'hFFFF_FFFF, 5'd31, 1);
        do_op("sra31", 3'b100, 32'h8000_0000, 5'd31, 0);
        do_op("sll15", 3'b000, 32'h0000_ABCD, 5'd15, 0);
        do_op("sll16", 3'b000, 32'h0000_ABCD, 5'd16, 0);
        do_op("ror17", 3'b011, 32'h0F0F_1234, 5'd17, 0);
        do_op("op7", 3'b111, 32'h0000_00F1, 5'd8, 0);
        do_op("op5", 3'b101, 32'h0000_0003, 5'd30, 0);

        // Reset in the middle of a 3-pass SLL.
        bus.req_op    = 3'b000;
        bus.req_data  = 32'h0000_0001;
        bus.req_amt   = 5'd31;
        bus.req_valid = 1'b1;
        @(posedge clk); @(negedge clk);
        bus.req_valid = 1'b0;
        check("mrst/busy_run", 32'(busy), 32'd1);
        check("mrst/step1", 32'(sh_shift), 32'd15);
        @(posedge clk); @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); @(negedge clk);
        check("mrst/busy", 32'(busy), 32'd0);
        check("mrst/res_valid", 32'(bus.res_valid), 32'd0);
        check("mrst/res_data", bus.res_data, 32'h0);
        check("mrst/sh_sr1", sh_sr1, 32'h0);
        check("mrst/sh_shift", 32'(sh_shift), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); @(negedge clk);
        check("mrst/res_valid_idle", 32'(bus.res_valid), 32'd0);
        do_op("after_rst", 3'b000, 32'h1234_5678, 5'd31, 0);

        for (int i = 0; i < 20; i++) begin
            do_op("rand", 3'($urandom_range(0, 7)), $urandom(), 5'($urandom_range(0, 31)),
                  int'($urandom_range(0, 2)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
